// File: rtl/hex_print_engine.sv
// hex_print_engine
//   Turns a print request into a byte stream for a UART transmitter. A type-0
//   request sends dout_tx[7:0] raw. A type-1 request sends the 32-bit word as
//   eight uppercase hex digits, MSB nibble first, followed by SEP_CHAR.
//
// Ports
//   clk      system clock, rising edge
//   rstn     asynchronous active-low reset
//   req_tx   print request level, held by the requester until ack_tx
//   type_tx  0 = raw character, 1 = 32-bit hex word
//   dout_tx  data to print, captured on acceptance
//   ack_tx   one-cycle pulse once the request is fully transmitted
//   d_tx     byte to the transmitter
//   vld_tx   d_tx valid
//   rdy_tx   transmitter can accept a byte
//
// state | meaning
// IDLE  | waiting for req_tx, captures dout_tx/type_tx on acceptance
// SEND  | presenting bytes, one transfer per vld_tx & rdy_tx edge
// ACK   | ack_tx high for this single cycle
// REL   | waiting for req_tx to drop so a held request is not re-accepted
module hex_print_engine #(
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] dout_tx,
  output logic        ack_tx,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] data_q, data_nxt;
  logic        type_q, type_nxt;
  logic [7:0]  d_nxt;
  logic        vld_nxt;
  logic        ack_nxt;
  logic [31:0] data_shifted;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
    else           hex_char = 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  // While cnt = c (3..9) is showing, the digit to present after the transfer
  // lives at bits [4*(c-3)+3 : 4*(c-3)] of the captured word.
  assign data_shifted = data_q >> {cnt - 4'd3, 2'b00};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      data_q <= 32'h0;
      type_q <= 1'b0;
      d_tx   <= 8'h00;
      vld_tx <= 1'b0;
      ack_tx <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      data_q <= data_nxt;
      type_q <= type_nxt;
      d_tx   <= d_nxt;
      vld_tx <= vld_nxt;
      ack_tx <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    type_nxt  = type_q;
    d_nxt     = d_tx;
    vld_nxt   = vld_tx;
    ack_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_tx) begin
          data_nxt  = dout_tx;
          type_nxt  = type_tx;
          cnt_nxt   = type_tx ? 4'd9 : 4'd1;
          d_nxt     = type_tx ? hex_char(dout_tx[31:28]) : dout_tx[7:0];
          vld_nxt   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (rdy_tx) begin
          if (cnt <= 4'd1) begin
            // final byte: stop presenting, pulse ack in the following cycle
            cnt_nxt   = 4'd0;
            vld_nxt   = 1'b0;
            ack_nxt   = 1'b1;
            state_nxt = ACK;
          end else begin
            cnt_nxt = cnt - 4'd1;
            if (type_q && cnt == 4'd2) d_nxt = SEP_CHAR;
            else                       d_nxt = hex_char(data_shifted[3:0]);
          end
        end
      end
      ACK: begin
        state_nxt = REL;
      end
      REL: begin
        if (!req_tx) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hex_print_engine.sv
module tb_hex_print_engine;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] dout_tx;
  logic        ack_tx;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx;

  int n_checks = 0;
  int n_fail   = 0;

  hex_print_engine #(.SEP_CHAR(8'h20)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req_tx  (req_tx),
    .type_tx (type_tx),
    .dout_tx (dout_tx),
    .ack_tx  (ack_tx),
    .d_tx    (d_tx),
    .vld_tx  (vld_tx),
    .rdy_tx  (rdy_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rstn = 1'b0; req_tx = 1'b0; type_tx = 1'b0; dout_tx = 32'h0; rdy_tx = 1'b0;
    #1;
    n_checks++;
    if (vld_tx !== 1'b0 || ack_tx !== 1'b0 || d_tx !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: vld=%b ack=%b d=%h, want 0 0 00", vld_tx, ack_tx, d_tx);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_raw_char();
    req_tx = 1'b1; type_tx = 1'b0; dout_tx = 32'h0000_0052; rdy_tx = 1'b1;
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b1 || d_tx !== 8'h52 || ack_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_byte: vld=%b d=%h ack=%b, want 1 52 0", vld_tx, d_tx, ack_tx);
    end
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b0 || ack_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_ack: vld=%b ack=%b, want 0 1", vld_tx, ack_tx);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (vld_tx !== 1'b0 || ack_tx !== 1'b0) begin
        n_fail++;
        $display("FAIL raw_held_%0d: vld=%b ack=%b, want 0 0", i, vld_tx, ack_tx);
      end
    end
    req_tx = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hex_word();
    logic [7:0] exp_b [9] = '{8'h31, 8'h41, 8'h32, 8'h42, 8'h33, 8'h43, 8'h34, 8'h46, 8'h20};
    req_tx = 1'b1; type_tx = 1'b1; dout_tx = 32'h1A2B_3C4F; rdy_tx = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_checks++;
      if (vld_tx !== 1'b1 || d_tx !== exp_b[c] || ack_tx !== 1'b0) begin
        n_fail++;
        $display("FAIL hex_byte_%0d: vld=%b d=%h ack=%b, want 1 %h 0", c, vld_tx, d_tx, ack_tx, exp_b[c]);
      end
      // requester lets go mid-print; the word must still finish and ack
      if (c == 4) req_tx = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b0 || ack_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL hex_ack: vld=%b ack=%b, want 0 1", vld_tx, ack_tx);
    end
    @(negedge clk);
    n_checks++;
    if (ack_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL hex_ack_width: ack=%b, want 0", ack_tx);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [9] = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h30, 8'h30, 8'h30, 8'h30, 8'h20};
    int   idx = 0;
    logic prev_vld = 1'b0;
    logic prev_rdy = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic got_ack = 1'b0;
    req_tx = 1'b1; type_tx = 1'b1; dout_tx = 32'hFFFF_0000; rdy_tx = 1'b0;
    for (int cyc = 0; cyc < 200 && !got_ack; cyc++) begin
      @(negedge clk);
      if (prev_vld && !prev_rdy) begin
        n_checks++;
        if (vld_tx !== 1'b1 || d_tx !== prev_d) begin
          n_fail++;
          $display("FAIL bp_stable_%0d: vld=%b d=%h, want 1 %h", cyc, vld_tx, d_tx, prev_d);
        end
      end
      if (ack_tx) begin
        got_ack = 1'b1;
      end else begin
        rdy_tx = 1'($urandom_range(0, 1));
        if (vld_tx && rdy_tx) begin
          n_checks++;
          if (idx > 8 || d_tx !== exp_b[idx > 8 ? 8 : idx]) begin
            n_fail++;
            $display("FAIL bp_byte_%0d: d=%h, want %h", idx, d_tx, exp_b[idx > 8 ? 8 : idx]);
          end
          idx++;
        end
      end
      prev_vld = vld_tx; prev_rdy = rdy_tx; prev_d = d_tx;
    end
    n_checks++;
    if (!got_ack || idx != 9) begin
      n_fail++;
      $display("FAIL bp_complete: ack_seen=%b bytes=%0d, want 1 9", got_ack, idx);
    end
    req_tx = 1'b0; rdy_tx = 1'b1;
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b0 || ack_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after: vld=%b ack=%b, want 0 0", vld_tx, ack_tx);
    end
    @(negedge clk);
  endtask

  task automatic test_input_change();
    logic [7:0] exp_b [9] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h20};
    req_tx = 1'b1; type_tx = 1'b1; dout_tx = 32'hDEAD_BEEF; rdy_tx = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        dout_tx = 32'h0;
        type_tx = 1'b0;
      end
      n_checks++;
      if (vld_tx !== 1'b1 || d_tx !== exp_b[c]) begin
        n_fail++;
        $display("FAIL chg_byte_%0d: vld=%b d=%h, want 1 %h", c, vld_tx, d_tx, exp_b[c]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b0 || ack_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL chg_ack: vld=%b ack=%b, want 0 1", vld_tx, ack_tx);
    end
    req_tx = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp_b [4] = '{8'h31, 8'h32, 8'h33, 8'h34};
    req_tx = 1'b1; type_tx = 1'b1; dout_tx = 32'h1234_5678; rdy_tx = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (vld_tx !== 1'b1 || d_tx !== exp_b[c]) begin
        n_fail++;
        $display("FAIL rst_pre_byte_%0d: vld=%b d=%h, want 1 %h", c, vld_tx, d_tx, exp_b[c]);
      end
    end
    rstn = 1'b0; req_tx = 1'b0;
    #1;
    n_checks++;
    if (vld_tx !== 1'b0 || ack_tx !== 1'b0 || d_tx !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_async: vld=%b ack=%b d=%h, want 0 0 00", vld_tx, ack_tx, d_tx);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b0 || ack_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_ack: vld=%b ack=%b, want 0 0", vld_tx, ack_tx);
    end
    req_tx = 1'b1; type_tx = 1'b0; dout_tx = 32'h0000_000A;
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b1 || d_tx !== 8'h0A) begin
      n_fail++;
      $display("FAIL rst_new_byte: vld=%b d=%h, want 1 0a", vld_tx, d_tx);
    end
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b0 || ack_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_new_ack: vld=%b ack=%b, want 0 1", vld_tx, ack_tx);
    end
    req_tx = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_release();
    req_tx = 1'b1; type_tx = 1'b0; dout_tx = 32'h0000_0051; rdy_tx = 1'b1;
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b1 || d_tx !== 8'h51) begin
      n_fail++;
      $display("FAIL hold_first: vld=%b d=%h, want 1 51", vld_tx, d_tx);
    end
    @(negedge clk);
    n_checks++;
    if (ack_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ack: ack=%b, want 1", ack_tx);
    end
    dout_tx = 32'h0000_0037;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (vld_tx !== 1'b0 || ack_tx !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_retrigger_%0d: vld=%b ack=%b, want 0 0", i, vld_tx, ack_tx);
      end
    end
    req_tx = 1'b0;
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_dropped: vld=%b, want 0", vld_tx);
    end
    req_tx = 1'b1;
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b1 || d_tx !== 8'h37) begin
      n_fail++;
      $display("FAIL hold_second: vld=%b d=%h, want 1 37", vld_tx, d_tx);
    end
    @(negedge clk);
    n_checks++;
    if (vld_tx !== 1'b0 || ack_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_second_ack: vld=%b ack=%b, want 0 1", vld_tx, ack_tx);
    end
    req_tx = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_raw_char();
    test_hex_word();
    test_backpressure();
    test_input_change();
    test_reset_mid_word();
    test_hold_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
